// File: rtl/pixel_fetch_scaler.sv
// Frame-buffer pixel fetcher: h/v counters -> RAM read address with integer replication,
// RGB returned 3 clks after the counters; fetch enable and state changes only at frame start.
module pixel_fetch_scaler #(
   parameter int H_ACTIVE   = 800,
   parameter int V_ACTIVE   = 600,
   parameter int COLOR_BITS = 2,
   parameter int SCALE      = 1,
   parameter int ADDR_W     = 19
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [10:0]               h_count,
   input  logic [9:0]                v_count,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_rd_en,
   input  logic [3*COLOR_BITS-1:0]   mem_data,
   output logic [COLOR_BITS-1:0]     red,
   output logic [COLOR_BITS-1:0]     green,
   output logic [COLOR_BITS-1:0]     blue,
   output logic                      pix_active,
   output logic                      frame_start
);

   localparam int SRC_W    = H_ACTIVE / SCALE;
   localparam int MAX_ADDR = SRC_W * (V_ACTIVE / SCALE) - 1;
   localparam logic [2:0] REP_LAST = 3'(SCALE - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state;
   logic [ADDR_W-1:0] line_base, x_src;
   logic [2:0]        x_rep, y_rep;
   logic              fs1, vis2, fs2;

   logic              fs, visible, line_end, run_now, base_ok;
   logic [ADDR_W-1:0] base_c, xs_c;
   logic [2:0]        xr_c, yr_c;
   logic [ADDR_W:0]   next_base;

   // Frame start zeroes the counters combinationally so pixel (0,0) reads address 0.
   always_comb begin
      fs        = (h_count == 11'd0) && (v_count == 10'd0);
      visible   = (h_count < 11'(H_ACTIVE)) && (v_count < 10'(V_ACTIVE));
      line_end  = (h_count == 11'(H_ACTIVE - 1));
      run_now   = fs ? en : (state == RUN);
      base_c    = fs ? '0 : line_base;
      xs_c      = fs ? '0 : x_src;
      xr_c      = fs ? '0 : x_rep;
      yr_c      = fs ? '0 : y_rep;
      next_base = {1'b0, base_c} + (ADDR_W+1)'(SRC_W);
      // Saturating guards keep any address within the frame when the counters jump.
      base_ok   = next_base <= (ADDR_W+1)'(MAX_ADDR + 1 - SRC_W);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         mem_addr    <= '0;
         mem_rd_en   <= 1'b0;
         line_base   <= '0;
         x_src       <= '0;
         x_rep       <= '0;
         y_rep       <= '0;
         fs1         <= 1'b0;
         vis2        <= 1'b0;
         fs2         <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         pix_active  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         if (fs) begin
            state     <= en ? RUN : IDLE;
            line_base <= '0;
            x_src     <= '0;
            x_rep     <= '0;
            y_rep     <= '0;
         end
         mem_rd_en <= visible && run_now;
         fs1       <= fs && en;
         vis2      <= mem_rd_en;
         fs2       <= fs1;
         pix_active  <= vis2;
         frame_start <= fs2;
         {red, green, blue} <= vis2 ? mem_data : '0;

         if (visible && run_now) begin
            mem_addr <= base_c + xs_c;
            if (line_end) begin
               x_src <= '0;
               x_rep <= '0;
               if (yr_c == REP_LAST) begin
                  y_rep     <= '0;
                  line_base <= base_ok ? next_base[ADDR_W-1:0] : base_c;
               end else begin
                  y_rep     <= yr_c + 3'd1;
                  line_base <= base_c;
               end
            end else if (xr_c == REP_LAST) begin
               x_rep <= '0;
               if (xs_c < ADDR_W'(SRC_W - 1))
                  x_src <= xs_c + 1'b1;
               else
                  x_src <= xs_c;
            end else begin
               x_rep <= xr_c + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pixel_fetch_scaler.sv
// Bench for pixel_fetch_scaler: full-size instance for fixed-value checks, small SCALE=2
// instance checked cycle by cycle against an arithmetic reference model.
module tb_pixel_fetch_scaler;

   localparam int BH = 32, BV = 16, BS = 2, BW = 8;
   localparam int BSW = BH / BS, BMAX = BSW * (BV / BS) - 1;
   localparam int BHT = 40, BVT = 20;

   int n_checks = 0;
   int n_errors = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // full-size instance
   logic        a_rst_n = 1'b0, a_en = 1'b0, a_force = 1'b0;
   logic [10:0] a_h = '0;
   logic [9:0]  a_v = '0;
   logic [18:0] a_addr;
   logic        a_rd, a_pix, a_fs;
   logic [5:0]  a_data = '0;
   logic [1:0]  a_r, a_g, a_b;

   // small scaled instance
   logic        b_rst_n = 1'b0, b_en = 1'b0;
   logic [10:0] b_h = '0;
   logic [9:0]  b_v = '0;
   logic [7:0]  b_addr;
   logic        b_rd, b_pix, b_fs;
   logic [5:0]  b_data = '0;
   logic [1:0]  b_r, b_g, b_b;

   pixel_fetch_scaler u_a (
      .clk(clk), .rst_n(a_rst_n), .en(a_en), .h_count(a_h), .v_count(a_v),
      .mem_addr(a_addr), .mem_rd_en(a_rd), .mem_data(a_data),
      .red(a_r), .green(a_g), .blue(a_b), .pix_active(a_pix), .frame_start(a_fs));

   pixel_fetch_scaler #(.H_ACTIVE(BH), .V_ACTIVE(BV), .COLOR_BITS(2), .SCALE(BS), .ADDR_W(BW)) u_b (
      .clk(clk), .rst_n(b_rst_n), .en(b_en), .h_count(b_h), .v_count(b_v),
      .mem_addr(b_addr), .mem_rd_en(b_rd), .mem_data(b_data),
      .red(b_r), .green(b_g), .blue(b_b), .pix_active(b_pix), .frame_start(b_fs));

   function automatic logic [5:0] ramb(input logic [7:0] a);
      logic [7:0] t;
      t = a * 8'd3 + 8'd7;
      return t[5:0] ^ 6'h15;
   endfunction

   // synchronous RAMs: data one clock after the address
   always @(posedge clk) a_data <= a_force ? 6'h3F : a_addr[5:0];
   always @(posedge clk) b_data <= ramb(b_addr);

   // reference model state for the small instance
   bit         m_run = 1'b0, m_rd = 1'b0;
   logic [7:0] m_addr = '0;
   bit         q_pix[3];
   bit         q_fs[3];
   logic [5:0] q_rgb[3];

   task automatic a_cycle(input int h, input int v);
      a_h = 11'(h);
      a_v = 10'(v);
      @(posedge clk);
      #1;
   endtask

   task automatic b_cycle(input bit en, input int h, input int v);
      bit fs, vis, live;
      b_en = en;
      b_h  = 11'(h);
      b_v  = 10'(v);
      fs   = (h == 0) && (v == 0);
      vis  = (h < BH) && (v < BV);
      if (fs) m_run = en;
      live = vis && m_run;
      if (live) m_addr = 8'((v / BS) * BSW + h / BS);
      m_rd = live;
      for (int i = 2; i > 0; i--) begin
         q_pix[i] = q_pix[i-1];
         q_fs[i]  = q_fs[i-1];
         q_rgb[i] = q_rgb[i-1];
      end
      q_pix[0] = live;
      q_fs[0]  = fs && m_run;
      q_rgb[0] = live ? ramb(m_addr) : 6'd0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      a_en = 1'b1;
      b_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({a_addr, a_rd, a_r, a_g, a_b, a_pix, a_fs} !== '0) begin
         n_errors++;
         $display("FAIL reset_a got %h want 0", {a_addr, a_rd, a_r, a_g, a_b, a_pix, a_fs});
      end
      n_checks++;
      if ({b_addr, b_rd, b_r, b_g, b_b, b_pix, b_fs} !== '0) begin
         n_errors++;
         $display("FAIL reset_b got %h want 0", {b_addr, b_rd, b_r, b_g, b_b, b_pix, b_fs});
      end
      b_en = 1'b0;
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
   endtask

   task automatic test_pixel_fetch;
      int k;
      k = -1;
      a_en = 1'b1;
      for (int v = 0; v < 3; v++) begin
         for (int h = 0; h < 1056; h++) begin
            a_cycle(h, v);
            if (h == 0 && v == 0) begin
               n_checks++;
               if ({a_rd, a_addr} !== {1'b1, 19'd0}) begin
                  n_errors++;
                  $display("FAIL first_addr got %0b/%0d want 1/0", a_rd, a_addr);
               end
            end
            if (v == 0 && (h == 2 || h == 3)) begin
               n_checks++;
               if (a_fs !== (h == 2)) begin
                  n_errors++;
                  $display("FAIL frame_start_a h=%0d got %0b want %0b", h, a_fs, h == 2);
               end
            end
            if (h == 5 && v == 2) begin
               k = 0;
               n_checks++;
               if ({a_rd, a_addr} !== {1'b1, 19'd1605}) begin
                  n_errors++;
                  $display("FAIL addr_5_2 got %0b/%0d want 1/1605", a_rd, a_addr);
               end
            end else if (k >= 0) begin
               k++;
               if (k == 2) begin
                  n_checks++;
                  if ({a_pix, a_r, a_g, a_b} !== {1'b1, 6'h05}) begin
                     n_errors++;
                     $display("FAIL rgb_5_2 got %0b/%h want 1/05", a_pix, {a_r, a_g, a_b});
                  end
               end
            end
         end
      end
   endtask

   task automatic test_blanking;
      for (int h = 0; h < 800; h++) a_cycle(h, 3);
      a_force = 1'b1;
      for (int h = 800; h < 1056; h++) begin
         a_cycle(h, 3);
         n_checks++;
         if (a_rd !== 1'b0) begin
            n_errors++;
            $display("FAIL hblank_rd h=%0d got %0b want 0", h, a_rd);
         end
         if (h >= 802) begin
            n_checks++;
            if ({a_pix, a_r, a_g, a_b} !== 7'd0) begin
               n_errors++;
               $display("FAIL hblank_rgb h=%0d got %h want 0", h, {a_pix, a_r, a_g, a_b});
            end
         end
      end
      for (int h = 0; h < 10; h++) begin
         a_cycle(h, 600);
         n_checks++;
         if ({a_rd, a_pix, a_r, a_g, a_b} !== 8'd0) begin
            n_errors++;
            $display("FAIL vblank h=%0d got %h want 0", h, {a_rd, a_pix, a_r, a_g, a_b});
         end
      end
      a_force = 1'b0;
   endtask

   task automatic test_reset_midline;
      a_en = 1'b1;
      for (int h = 0; h < 100; h++) a_cycle(h, 0);
      #2;
      a_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({a_addr, a_rd, a_r, a_g, a_b, a_pix, a_fs} !== '0) begin
         n_errors++;
         $display("FAIL async_reset got %h want 0", {a_addr, a_rd, a_r, a_g, a_b, a_pix, a_fs});
      end
      #2;
      a_rst_n = 1'b1;
      for (int v = 0; v < 2; v++) begin
         for (int h = (v == 0) ? 100 : 0; h < 1056; h++) begin
            a_cycle(h, v);
            n_checks++;
            if ({a_rd, a_pix, a_fs} !== 3'd0) begin
               n_errors++;
               $display("FAIL idle_after_reset h=%0d v=%0d got %b want 000", h, v, {a_rd, a_pix, a_fs});
            end
         end
      end
      a_cycle(0, 0);
      n_checks++;
      if ({a_rd, a_addr} !== {1'b1, 19'd0}) begin
         n_errors++;
         $display("FAIL resume_after_reset got %0b/%0d want 1/0", a_rd, a_addr);
      end
      a_cycle(1, 0);
      a_cycle(2, 0);
      n_checks++;
      if (a_fs !== 1'b1) begin
         n_errors++;
         $display("FAIL fs_after_reset got %0b want 1", a_fs);
      end
   endtask

   task automatic test_scale;
      logic [7:0] tab[4] = '{8'd0, 8'd0, 8'd1, 8'd1};
      for (int v = 0; v < BVT; v++) begin
         for (int h = 0; h < BHT; h++) begin
            b_cycle(1'b1, h, v);
            n_checks++;
            if ({b_rd, b_pix, b_fs, b_r, b_g, b_b} !== {m_rd, q_pix[2], q_fs[2], q_rgb[2]}) begin
               n_errors++;
               $display("FAIL scale_out h=%0d v=%0d got %h want %h", h, v,
                        {b_rd, b_pix, b_fs, b_r, b_g, b_b}, {m_rd, q_pix[2], q_fs[2], q_rgb[2]});
            end
            if (m_rd) begin
               n_checks++;
               if (b_addr !== m_addr) begin
                  n_errors++;
                  $display("FAIL scale_addr h=%0d v=%0d got %0d want %0d", h, v, b_addr, m_addr);
               end
            end
            if ((v < 2 && h < 4) || (v == 2 && h == 0) || (v == BV-1 && h == BH-1)) begin
               n_checks++;
               if (b_addr !== ((v < 2) ? tab[h] : (v == 2) ? 8'd16 : 8'(BMAX))) begin
                  n_errors++;
                  $display("FAIL scale_fixed h=%0d v=%0d got %0d", h, v, b_addr);
               end
            end
         end
      end
   endtask

   task automatic test_enable;
      for (int f = 0; f < 3; f++) begin
         for (int v = 0; v < BVT; v++) begin
            for (int h = 0; h < BHT; h++) begin
               b_cycle((f == 0) ? (v < BV/2) : (f == 1) ? (v >= 5) : 1'b1, h, v);
               n_checks++;
               if ({b_rd, b_pix, b_fs, b_r, b_g, b_b} !== {m_rd, q_pix[2], q_fs[2], q_rgb[2]}) begin
                  n_errors++;
                  $display("FAIL enable_out f=%0d h=%0d v=%0d got %h want %h", f, h, v,
                           {b_rd, b_pix, b_fs, b_r, b_g, b_b}, {m_rd, q_pix[2], q_fs[2], q_rgb[2]});
               end
               if (m_rd) begin
                  n_checks++;
                  if (b_addr !== m_addr) begin
                     n_errors++;
                     $display("FAIL enable_addr f=%0d h=%0d v=%0d got %0d want %0d", f, h, v, b_addr, m_addr);
                  end
               end
               if (f == 0 && v == BV-1 && h == BH-1) begin
                  n_checks++;
                  if ({b_rd, b_addr} !== {1'b1, 8'(BMAX)}) begin
                     n_errors++;
                     $display("FAIL en_drop_completes got %0b/%0d want 1/%0d", b_rd, b_addr, BMAX);
                  end
               end
               if (f == 1) begin
                  n_checks++;
                  if ({b_rd, b_pix, b_fs, b_r, b_g, b_b} !== 9'd0) begin
                     n_errors++;
                     $display("FAIL idle_frame h=%0d v=%0d got %h want 0", h, v, {b_rd, b_pix, b_fs, b_r, b_g, b_b});
                  end
               end
               if (f == 2 && v == 0 && h == 0) begin
                  n_checks++;
                  if ({b_rd, b_addr} !== {1'b1, 8'd0}) begin
                     n_errors++;
                     $display("FAIL resume_addr got %0b/%0d want 1/0", b_rd, b_addr);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int fs_cnt, fs_pos, idx;
      for (int f = 0; f < 2; f++) begin
         fs_cnt = 0;
         fs_pos = -1;
         idx = 0;
         for (int v = 0; v < BVT; v++) begin
            for (int h = 0; h < BHT; h++) begin
               b_cycle(1'b1, h, v);
               if (b_fs === 1'b1) begin
                  fs_cnt++;
                  fs_pos = idx;
               end
               if (idx == 0) begin
                  n_checks++;
                  if ({b_rd, b_addr} !== {1'b1, 8'd0}) begin
                     n_errors++;
                     $display("FAIL b2b_first_addr f=%0d got %0b/%0d want 1/0", f, b_rd, b_addr);
                  end
               end
               idx++;
            end
         end
         n_checks++;
         if (fs_cnt !== 1 || fs_pos !== 2) begin
            n_errors++;
            $display("FAIL b2b_frame_start f=%0d got count %0d at %0d want 1 at 2", f, fs_cnt, fs_pos);
         end
      end
   endtask

   task automatic test_discontinuity;
      for (int v = 0; v < 3; v++)
         for (int h = 0; h < BHT; h++) b_cycle(1'b1, h, v);
      for (int i = 0; i < 300; i++) begin
         b_cycle(1'b1, $urandom_range(0, BHT-1), $urandom_range(1, BVT-1));
         n_checks++;
         if (b_rd === 1'b1 && b_addr > 8'(BMAX)) begin
            n_errors++;
            $display("FAIL jump_bound i=%0d got %0d want <= %0d", i, b_addr, BMAX);
         end
      end
      for (int h = BH; h < BHT; h++) b_cycle(1'b1, h, BV);
      for (int v = 0; v < BVT; v++) begin
         for (int h = 0; h < BHT; h++) begin
            b_cycle(1'b1, h, v);
            n_checks++;
            if ({b_rd, b_pix, b_fs, b_r, b_g, b_b} !== {m_rd, q_pix[2], q_fs[2], q_rgb[2]}) begin
               n_errors++;
               $display("FAIL resync_out h=%0d v=%0d got %h want %h", h, v,
                        {b_rd, b_pix, b_fs, b_r, b_g, b_b}, {m_rd, q_pix[2], q_fs[2], q_rgb[2]});
            end
            if (m_rd) begin
               n_checks++;
               if (b_addr !== m_addr) begin
                  n_errors++;
                  $display("FAIL resync_addr h=%0d v=%0d got %0d want %0d", h, v, b_addr, m_addr);
               end
            end
         end
      end
   endtask

   task automatic test_random;
      bit fen;
      for (int f = 0; f < 5; f++) begin
         fen = (f == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         for (int v = 0; v < BVT; v++) begin
            for (int h = 0; h < BHT; h++) begin
               b_cycle((h == 0 && v == 0) ? fen : 1'($urandom_range(0, 1)), h, v);
               n_checks++;
               if ({b_rd, b_pix, b_fs, b_r, b_g, b_b} !== {m_rd, q_pix[2], q_fs[2], q_rgb[2]}) begin
                  n_errors++;
                  $display("FAIL random_out f=%0d h=%0d v=%0d got %h want %h", f, h, v,
                           {b_rd, b_pix, b_fs, b_r, b_g, b_b}, {m_rd, q_pix[2], q_fs[2], q_rgb[2]});
               end
               if (m_rd) begin
                  n_checks++;
                  if (b_addr !== m_addr) begin
                     n_errors++;
                     $display("FAIL random_addr f=%0d h=%0d v=%0d got %0d want %0d", f, h, v, b_addr, m_addr);
                  end
               end
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         q_pix[i] = 1'b0;
         q_fs[i]  = 1'b0;
         q_rgb[i] = '0;
      end
      test_reset;
      test_pixel_fetch;
      test_blanking;
      test_reset_midline;
      test_scale;
      test_enable;
      test_back_to_back;
      test_discontinuity;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
